// File: rtl/jump_pkg.sv
// Shared definitions for the jump physics block: channel state encoding and
// default parameter values used by the top level and each channel.
package jump_pkg;

  localparam int NUM_P_DEF     = 2;
  localparam int Y_W_DEF       = 16;
  localparam int TICK_DIV_DEF  = 500000;
  localparam int JUMP_H_DEF    = 60;
  localparam int CEIL_Y_DEF    = 0;
  localparam int GROUND_Y_DEF  = 180;
  localparam int MAX_JUMPS_DEF = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RISE = ST_RISE,
    S_FALL = ST_FALL
  } jump_state_e;

endpackage

// File: rtl/jump_physics_if.sv
// Player-side bundle: positions and buttons in, movement strobes and status out.
interface jump_physics_if #(
  parameter int NUM_P = 2,
  parameter int Y_W   = 16,
  parameter int JC_W  = 2
);
  // up_cmd/drop_cmd are single-cycle strobes acting as their own valid; there
  // is no ready: the player logic must consume each strobe in the cycle seen.
  logic [NUM_P*Y_W-1:0]  p_y;
  logic [NUM_P-1:0]      jump_btn;
  logic                  freeze;
  logic [NUM_P-1:0]      up_cmd;
  logic [NUM_P-1:0]      drop_cmd;
  logic [NUM_P-1:0]      airborne;
  logic [NUM_P*JC_W-1:0] jumps_used;
  logic [NUM_P*2-1:0]    dbg_state;

  modport master (
    output p_y, jump_btn, freeze,
    input  up_cmd, drop_cmd, airborne, jumps_used, dbg_state
  );

  modport slave (
    input  p_y, jump_btn, freeze,
    output up_cmd, drop_cmd, airborne, jumps_used, dbg_state
  );
endinterface

// File: rtl/jump_channel.sv
// One player's jump FSM (IDLE/RISE/FALL) with tick divider, apex target and
// multi-jump accounting. All outputs are registered.
module jump_channel
  import jump_pkg::*;
#(
  parameter int Y_W       = Y_W_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int JUMP_H    = JUMP_H_DEF,
  parameter int CEIL_Y    = CEIL_Y_DEF,
  parameter int GROUND_Y  = GROUND_Y_DEF,
  parameter int MAX_JUMPS = MAX_JUMPS_DEF,
  localparam int JC_W     = $clog2(MAX_JUMPS + 1),
  localparam int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Y_W-1:0]  y_i,
  input  logic            btn_i,
  input  logic            freeze_i,
  output logic            up_o,
  output logic            drop_o,
  output logic            airborne_o,
  output logic [JC_W-1:0] jumps_o,
  output logic [1:0]      state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [Y_W:0]     LIFT_MIN  = (Y_W + 1)'(CEIL_Y + JUMP_H);
  localparam logic [Y_W-1:0]   JUMP_H_Y  = Y_W'(JUMP_H);
  localparam logic [Y_W-1:0]   CEIL_YV   = Y_W'(CEIL_Y);
  localparam logic [Y_W-1:0]   GROUND_YV = Y_W'(GROUND_Y);
  localparam logic [JC_W-1:0]  MAX_J     = JC_W'(MAX_JUMPS);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]  target_q, target_d;
  logic [JC_W-1:0] jumps_q, jumps_d;
  logic            btn_prev_q, btn_prev_d;
  logic            armed_q, armed_d;
  logic            up_q, up_d;
  logic            drop_q, drop_d;
  logic            airborne_q, airborne_d;
  logic            jump_ev;
  logic [Y_W-1:0]  target_new;

  // armed_q stays low for the first cycle after reset so a button held
  // through reset release is absorbed into the edge history, not a jump.
  always_comb begin
    jump_ev    = armed_q & btn_i & ~btn_prev_q & ~freeze_i;
    target_new = ({1'b0, y_i} >= LIFT_MIN) ? (y_i - JUMP_H_Y) : CEIL_YV;
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    jumps_d    = jumps_q;
    btn_prev_d = btn_i;
    armed_d    = 1'b1;
    up_d       = 1'b0;
    drop_d     = 1'b0;
    if (!freeze_i) begin
      if (jump_ev && (jumps_q < MAX_J)) begin
        state_d  = ST_RISE;
        target_d = target_new;
        cnt_d    = '0;
        jumps_d  = jumps_q + JC_W'(1);
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_RISE: begin
            if (y_i <= target_q) begin
              state_d = ST_FALL;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              up_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_FALL: begin
            if (y_i >= GROUND_YV) begin
              state_d = ST_IDLE;
              jumps_d = '0;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_d  = '0;
              drop_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    airborne_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      jumps_q    <= '0;
      btn_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      up_q       <= 1'b0;
      drop_q     <= 1'b0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      jumps_q    <= jumps_d;
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      up_q       <= up_d;
      drop_q     <= drop_d;
      airborne_q <= airborne_d;
    end
  end

  assign up_o       = up_q;
  assign drop_o     = drop_q;
  assign airborne_o = airborne_q;
  assign jumps_o    = jumps_q;
  assign state_o    = state_q;

endmodule

// File: rtl/jump_physics.sv
// Multi-player jump physics: NUM_P independent jump channels sharing a clock
// and a global freeze.
module jump_physics
  import jump_pkg::*;
#(
  parameter int NUM_P     = NUM_P_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int JUMP_H    = JUMP_H_DEF,
  parameter int CEIL_Y    = CEIL_Y_DEF,
  parameter int GROUND_Y  = GROUND_Y_DEF,
  parameter int MAX_JUMPS = MAX_JUMPS_DEF,
  localparam int JC_W     = $clog2(MAX_JUMPS + 1)
) (
  input logic           clk,
  input logic           rst,
  jump_physics_if.slave bus
);

  logic [NUM_P-1:0]      up_w;
  logic [NUM_P-1:0]      drop_w;
  logic [NUM_P-1:0]      air_w;
  logic [NUM_P*JC_W-1:0] jc_w;
  logic [NUM_P*2-1:0]    st_w;

  for (genvar i = 0; i < NUM_P; i++) begin : g_ch
    jump_channel #(
      .Y_W      (Y_W),
      .TICK_DIV (TICK_DIV),
      .JUMP_H   (JUMP_H),
      .CEIL_Y   (CEIL_Y),
      .GROUND_Y (GROUND_Y),
      .MAX_JUMPS(MAX_JUMPS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .y_i       (bus.p_y[i*Y_W +: Y_W]),
      .btn_i     (bus.jump_btn[i]),
      .freeze_i  (bus.freeze),
      .up_o      (up_w[i]),
      .drop_o    (drop_w[i]),
      .airborne_o(air_w[i]),
      .jumps_o   (jc_w[i*JC_W +: JC_W]),
      .state_o   (st_w[i*2 +: 2])
    );
  end

  assign bus.up_cmd     = up_w;
  assign bus.drop_cmd   = drop_w;
  assign bus.airborne   = air_w;
  assign bus.jumps_used = jc_w;
  assign bus.dbg_state  = st_w;

endmodule

// File: tb/tb_jump_physics.sv
// Bench for jump_physics: a player model applies strobes to y, a monitor
// compares each strobe against a queue of hand-derived expected pulses.
module tb_jump_physics;
  localparam int NUM_P = 2;
  localparam int Y_W   = 16;
  localparam int TICK  = 4;
  localparam int JC_W  = 2;
  localparam int W     = 32;
  localparam int DIR_UP = 1;
  localparam int DIR_DN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jump_physics_if #(.NUM_P(NUM_P), .Y_W(Y_W), .JC_W(JC_W)) bus ();

  jump_physics #(
    .NUM_P(NUM_P), .Y_W(Y_W), .TICK_DIV(TICK), .JUMP_H(60),
    .CEIL_Y(0), .GROUND_Y(180), .MAX_JUMPS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [Y_W-1:0] y_m [NUM_P];
  assign bus.p_y = {y_m[1], y_m[0]};

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frz_tot = 0;
  logic frz_q = 1'b0;
  int epoch[NUM_P];
  int last_t[NUM_P];
  int last_dir[NUM_P];
  int last_ep[NUM_P];
  int last_frz[NUM_P];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int ch, input int dir, input int y);
    logic [W-1:0] item;
    item = {8'(ch), 8'(dir), 16'(y)};
    if (ch == 0) exp_q0.push_back(item);
    else exp_q1.push_back(item);
  endtask

  // Strobes seen at y = hi, hi-1, ... lo+1 (player ends at lo).
  task automatic push_up(input int ch, input int hi, input int lo);
    for (int y = hi; y > lo; y--) push(ch, DIR_UP, y);
  endtask

  task automatic push_dn(input int ch, input int lo, input int hi);
    for (int y = lo; y < hi; y++) push(ch, DIR_DN, y);
  endtask

  task automatic press(input int ch, input bit restarts);
    if (restarts) epoch[ch]++;
    bus.jump_btn[ch] = 1'b1;
    tick(1);
    bus.jump_btn[ch] = 1'b0;
    tick(1);
  endtask

  task automatic wait_y(input int ch, input int val, input int budget);
    int n;
    n = 0;
    while (y_m[ch] != val && n < budget) begin
      tick(1);
      n++;
    end
    check($sformatf("wait_y%0d", ch), y_m[ch], val);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || bus.airborne != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check("pending_p0", exp_q0.size(), 0);
    check("pending_p1", exp_q1.size(), 0);
    check("airborne_end", bus.airborne, 0);
    check("jumps_end", bus.jumps_used, 0);
  endtask

  task automatic edge_counter();
    forever begin
      @(posedge clk);
      cyc++;
      if (bus.freeze) frz_tot++;
      frz_q = bus.freeze;
    end
  endtask

  task automatic monitor();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    int dir;
    bit have;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_P; ch++) begin
        if (bus.up_cmd[ch] && bus.drop_cmd[ch]) begin
          check($sformatf("both_pulses_p%0d", ch), 1, 0);
        end else if (bus.up_cmd[ch] || bus.drop_cmd[ch]) begin
          dir = bus.up_cmd[ch] ? DIR_UP : DIR_DN;
          act = {8'(ch), 8'(dir), y_m[ch]};
          have = (ch == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          if (!have) begin
            check($sformatf("unexpected_pulse_p%0d", ch), int'(act), 0);
          end else begin
            exp = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("pulse_p%0d", ch), int'(act), int'(exp));
          end
          if (frz_q) check($sformatf("pulse_in_freeze_p%0d", ch), 1, 0);
          if (last_t[ch] >= 0 && last_dir[ch] == dir && last_ep[ch] == epoch[ch])
            check($sformatf("gap_p%0d", ch), cyc - last_t[ch], TICK + frz_tot - last_frz[ch]);
          last_t[ch]   = cyc;
          last_dir[ch] = dir;
          last_ep[ch]  = epoch[ch];
          last_frz[ch] = frz_tot;
          y_m[ch] = (dir == DIR_UP) ? y_m[ch] - 16'd1 : y_m[ch] + 16'd1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.jump_btn = '0;
    bus.freeze = 1'b0;
    for (int i = 0; i < NUM_P; i++) begin
      y_m[i] = 16'd180;
      epoch[i] = 0;
      last_t[i] = -1;
      last_dir[i] = 0;
      last_ep[i] = 0;
      last_frz[i] = 0;
    end
    fork
      edge_counter();
      monitor();
    join_none

    tick(3);
    check("rst_up", bus.up_cmd, 0);
    check("rst_drop", bus.drop_cmd, 0);
    check("rst_airborne", bus.airborne, 0);
    check("rst_jumps", bus.jumps_used, 0);
    check("rst_state", bus.dbg_state, 0);
    rst = 1'b0;
    tick(2);

    // Single jump from the ground: rise 60, fall back.
    push_up(0, 180, 120);
    push_dn(0, 120, 180);
    press(0, 1'b1);
    tick(1);
    check("s1_state_rise", bus.dbg_state[1:0], 1);
    check("s1_airborne", bus.airborne[0], 1);
    check("s1_jumps", bus.jumps_used[1:0], 1);
    wait_done(1200);
    check("s1_y_final", y_m[0], 180);

    // Double jump at y=150 re-latches target 90; third press ignored.
    push_up(0, 180, 90);
    push_dn(0, 90, 180);
    press(0, 1'b1);
    wait_y(0, 150, 400);
    press(0, 1'b1);
    tick(1);
    check("s2_jumps_two", bus.jumps_used[1:0], 2);
    check("s2_state_rise", bus.dbg_state[1:0], 1);
    tick(5);
    press(0, 1'b0);
    tick(1);
    check("s2_third_ignored", bus.jumps_used[1:0], 2);
    wait_done(2000);
    check("s2_y_final", y_m[0], 180);

    // Jump from y=40: target saturates to the ceiling at 0.
    y_m[0] = 16'd40;
    tick(1);
    push_up(0, 40, 0);
    push_dn(0, 0, 180);
    press(0, 1'b1);
    wait_y(0, 0, 400);
    wait_done(1500);
    check("s3_y_final", y_m[0], 180);

    // Freeze 10 cycles mid-rise with a press inside the freeze.
    push_up(0, 180, 120);
    push_dn(0, 120, 180);
    press(0, 1'b1);
    wait_y(0, 160, 300);
    tick(1);
    bus.freeze = 1'b1;
    tick(3);
    bus.jump_btn[0] = 1'b1;
    tick(3);
    check("s4_state_held", bus.dbg_state[1:0], 1);
    bus.jump_btn[0] = 1'b0;
    tick(4);
    bus.freeze = 1'b0;
    tick(2);
    check("s4_jumps_after_freeze", bus.jumps_used[1:0], 1);
    wait_done(1200);

    // Reset mid-fall with the button held.
    push_up(0, 180, 120);
    push_dn(0, 120, 150);
    press(0, 1'b1);
    wait_y(0, 120, 400);
    wait_y(0, 150, 400);
    bus.jump_btn[0] = 1'b1;
    rst = 1'b1;
    #1;
    check("s5_rst_up", bus.up_cmd, 0);
    check("s5_rst_drop", bus.drop_cmd, 0);
    check("s5_rst_airborne", bus.airborne, 0);
    check("s5_rst_jumps", bus.jumps_used, 0);
    check("s5_rst_state", bus.dbg_state, 0);
    check("s5_queue_drained", exp_q0.size(), 0);
    tick(3);
    rst = 1'b0;
    tick(10);
    check("s5_held_no_jump", bus.airborne[0], 0);
    check("s5_held_jumps", bus.jumps_used[1:0], 0);
    bus.jump_btn[0] = 1'b0;
    tick(1);
    push_up(0, 150, 90);
    push_dn(0, 90, 180);
    press(0, 1'b1);
    check("s5_rejump", bus.airborne[0], 1);
    wait_done(1500);
    check("s5_y_final", y_m[0], 180);

    // Both channels together, then a double jump on p1 alone.
    push_up(0, 180, 120);
    push_dn(0, 120, 180);
    push_up(1, 180, 90);
    push_dn(1, 90, 180);
    epoch[0]++;
    epoch[1]++;
    bus.jump_btn = 2'b11;
    tick(1);
    bus.jump_btn = 2'b00;
    tick(1);
    check("s6_both_airborne", bus.airborne, 3);
    wait_y(1, 150, 400);
    press(1, 1'b1);
    tick(1);
    check("s6_p0_jumps", bus.jumps_used[1:0], 1);
    check("s6_p1_jumps", bus.jumps_used[3:2], 2);
    wait_done(2000);
    check("s6_y0_final", y_m[0], 180);
    check("s6_y1_final", y_m[1], 180);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
